booth_divider: RTL and testbench



---
 rtl/booth_divider.sv | 170 +++++++++++++++++
 tb/tb_booth_divider.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_divider.sv
// booth_divider: sequential signed 2N/N divider (restoring, magnitude based, sign fix-up at the end).
// Latency: done pulses 2N+1 cycles after start is accepted; divide-by-zero completes after 1 cycle.
// Backpressure: none; start is only sampled in IDLE and is ignored while busy; issue interval >= 2N+2.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset (all outputs forced to 0)
//   start               - request, sampled only when idle
//   dividend [2N-1:0]   - signed dividend, captured on acceptance
//   divisor  [N-1:0]    - signed divisor, captured on acceptance
//   busy                - division in flight (DIVIDE/FIX)
//   done                - one-cycle pulse, results valid from this cycle
//   quotient [N-1:0]    - signed quotient, truncated toward zero
//   remainder[N-1:0]    - signed remainder, sign of the dividend
//   div_by_zero         - last operation had a zero divisor
//   overflow            - true quotient not representable in N signed bits
//
// Build option: BOOTH_DIVIDER_SAT_EN - saturate the quotient on overflow instead of truncating.

module booth_divider #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = $clog2(2*N);
  localparam logic [CW-1:0] LAST_ITER = CW'(2*N-1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIX    = 2'd2
  } state_t;

  state_t state, state_nx;

  // Datapath state. dq holds the dividend magnitude; as its bits shift out
  // the top, quotient bits shift in at the bottom, so after 2N steps it holds
  // the quotient magnitude.
  logic [2*N-1:0] dq;
  logic [N-1:0]   acc;        // partial remainder, always < |divisor|
  logic [N-1:0]   dvsr_mag;
  logic           sign_q;
  logic           sign_r;
  logic [CW-1:0]  cnt;
  logic           dz_pend;    // zero-divisor request accepted, reported next edge

  logic           accept;
  logic           dz_req;
  logic [2*N-1:0] dvd_mag;
  logic [N-1:0]   dvs_mag;
  logic [N:0]     shifted;
  logic           fits;
  logic [N-1:0]   acc_nx;
  logic [2*N:0]   q_signed;
  logic           q_ovf;
  logic [N-1:0]   q_out;
  logic [N-1:0]   r_signed;

  assign accept = (state == IDLE) && start && !dz_pend && (divisor != '0);
  assign dz_req = (state == IDLE) && start && !dz_pend && (divisor == '0);
  assign busy   = (state != IDLE);

  // Magnitudes as unsigned values: the most negative operand negates to
  // exactly 2^(width-1), which an unsigned register of the same width holds.
  assign dvd_mag = dividend[2*N-1] ? (~dividend + 1'b1) : dividend;
  assign dvs_mag = divisor[N-1]    ? (~divisor + 1'b1)  : divisor;

  // One restoring step. When the trial subtraction fits, the true result is
  // below |divisor| <= 2^(N-1), so an N-bit modular subtract is exact.
  assign shifted = {acc, dq[2*N-1]};
  assign fits    = (shifted >= {1'b0, dvsr_mag});
  assign acc_nx  = shifted[N-1:0] - (fits ? dvsr_mag : '0);

  // Sign fix-up. The quotient magnitude can reach 2^(2N-1), so the signed
  // form needs 2N+1 bits before the representability check.
  assign q_signed = sign_q ? -{1'b0, dq} : {1'b0, dq};
  assign q_ovf    = !((&q_signed[2*N:N-1]) || !(|q_signed[2*N:N-1]));
  assign r_signed = sign_r ? -acc : acc;

`ifdef BOOTH_DIVIDER_SAT_EN
  // A quotient that overflows is never zero, so sign_q gives its direction.
  assign q_out = q_ovf ? (sign_q ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}})
                       : q_signed[N-1:0];
`else
  assign q_out = q_signed[N-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = DIVIDE;
      DIVIDE:  if (cnt == LAST_ITER) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq          <= '0;
      acc         <= '0;
      dvsr_mag    <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      cnt         <= '0;
      dz_pend     <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done    <= 1'b0;
      dz_pend <= dz_req;

      if (dz_pend) begin
        quotient    <= '0;
        remainder   <= '0;
        div_by_zero <= 1'b1;
        overflow    <= 1'b0;
        done        <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            dq       <= dvd_mag;
            acc      <= '0;
            dvsr_mag <= dvs_mag;
            sign_q   <= dividend[2*N-1] ^ divisor[N-1];
            sign_r   <= dividend[2*N-1];
            cnt      <= '0;
          end
        end
        DIVIDE: begin
          acc <= acc_nx;
          dq  <= {dq[2*N-2:0], fits};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          quotient    <= q_out;
          remainder   <= r_signed;
          overflow    <= q_ovf;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// tb_booth_divider: scoreboard bench for booth_divider (N=8).
// Stimulus pushes integer-arithmetic expectations; a monitor pops them on done.
// Also tracks the expected busy window and done timing per accepted operation.

module tb_booth_divider;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [2*N-1:0] dividend = '0;
  logic [N-1:0]   divisor = '0;
  logic           busy;
  logic           done;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
  logic           overflow;

  booth_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
    int         due;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int compared   = 0;
  int mismatched = 0;
  int bsy_lo     = -1;
  int bsy_hi     = -2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer division (truncates toward zero, remainder
  // follows the dividend sign), then range check on the true quotient.
  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input int acc_edge);
    exp_t e;
    int sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) begin
      e.q = 8'h00; e.r = 8'h00; e.dz = 1'b1; e.ov = 1'b0;
      e.due = acc_edge + 1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      e.dz = 1'b0;
      e.ov = (q > 127) || (q < -128);
      e.r  = r[7:0];
`ifdef BOOTH_DIVIDER_SAT_EN
      if (e.ov) e.q = (q > 0) ? 8'h7F : 8'h80;
      else      e.q = q[7:0];
`else
      e.q = q[7:0];
`endif
      e.due = acc_edge + 2*N + 1;
    end
    return e;
  endfunction

  // Monitor: busy window every cycle, results and timing on each done.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", {31'd0, busy}, {31'd0, (cyc >= bsy_lo) && (cyc <= bsy_hi)});
      if (done) begin
        if (sbq.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL spurious_done: done=1 with no expected result (cycle %0d)", cyc);
        end else begin
          mon_e = sbq.pop_front();
          check("quotient",    {24'd0, quotient},    {24'd0, mon_e.q});
          check("remainder",   {24'd0, remainder},   {24'd0, mon_e.r});
          check("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dz});
          check("overflow",    {31'd0, overflow},    {31'd0, mon_e.ov});
          check("done_cycle",  cyc,                  mon_e.due);
        end
      end
    end
  end

  // Called at a negedge; start is accepted at the following rising edge.
  task automatic issue(input logic [15:0] a, input logic [7:0] b);
    int acc_edge;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    acc_edge = cyc;
    sbq.push_back(model(a, b, acc_edge));
    if (b != 8'h00) begin
      bsy_lo = acc_edge;
      bsy_hi = acc_edge + 2*N;
    end
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: done not seen, expected within 40 cycles", tag);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [7:0] b);
    issue(a, b);
    wait_done("op");
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, qq;
    logic [15:0] ra;
    logic [7:0]  rb;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",        {31'd0, busy},        32'd0);
    check("rst_done",        {31'd0, done},        32'd0);
    check("rst_quotient",    {24'd0, quotient},    32'd0);
    check("rst_remainder",   {24'd0, remainder},   32'd0);
    check("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    check("rst_overflow",    {31'd0, overflow},    32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(16'hFD1A, 8'h0E);   // -742 / 14
    run_op(16'h0410, 8'hCC);   // 1040 / -52
    run_op(16'hFF9C, 8'h07);   // -100 / 7
    run_op(16'h0410, 8'h02);   // overflow
    run_op(16'h8000, 8'hFF);   // most negative / -1
    run_op(16'h8000, 8'h80);
    run_op(16'h7FFF, 8'h80);
    run_op(16'hFF80, 8'h01);   // -128, just fits
    run_op(16'h0080, 8'hFF);   // -128, just fits
    run_op(16'h0080, 8'h01);   // 128, just overflows
    run_op(16'h0005, 8'h07);   // zero quotient, remainder = dividend
    run_op(16'hFFFB, 8'h07);

    // Divide by zero, then held flags, then a valid op clears it
    run_op(16'h1234, 8'h00);
    repeat (4) @(negedge clk);
    check("hold_div_by_zero", {31'd0, div_by_zero}, 32'd1);
    check("hold_quotient",    {24'd0, quotient},    32'd0);
    run_op(16'd154, 8'd14);

    // Reset in the middle of a divide
    issue(16'h7000, 8'h13);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy",        {31'd0, busy},        32'd0);
    check("abort_done",        {31'd0, done},        32'd0);
    check("abort_quotient",    {24'd0, quotient},    32'd0);
    check("abort_remainder",   {24'd0, remainder},   32'd0);
    check("abort_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    check("abort_overflow",    {31'd0, overflow},    32'd0);
    sbq.delete();
    bsy_lo = -1;
    bsy_hi = -2;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    run_op(16'd154, 8'd14);

    // Start while busy is ignored
    issue(16'hFC00, 8'h09);
    repeat (3) @(negedge clk);
    start    = 1'b1;
    dividend = 16'h0100;
    divisor  = 8'h03;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore");
    @(negedge clk);

    // Back-to-back: next start raised while done is high
    issue(16'h0321, 8'h0B);
    wait_done("b2b_a");
    issue(16'hF00F, 8'hF3);
    wait_done("b2b_b");
    @(negedge clk);

    // Randomized
    for (int i = 0; i < 150; i++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 9) == 0) rb = 8'h00;
      if ($urandom_range(0, 1) == 0) begin
        ra = 16'($urandom);
      end else begin
        qq = int'($urandom_range(0, 255)) - 128;
        t  = $signed(rb) * qq + int'($urandom_range(0, 3));
        ra = t[15:0];
      end
      run_op(ra, rb);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
